// File: rtl/imem_loader_pkg.sv
// Shared Y86 definitions for the instruction-memory loader: FSM states,
// fetch window size and the halt byte used to fill out-of-range fetches.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } ld_state_e;

    localparam int unsigned INSTR_MAX_BYTES = 10;
    localparam int unsigned INSTR_W         = 8 * INSTR_MAX_BYTES;
    localparam int unsigned PC_W            = 64;
    localparam logic [7:0]  HALT_BYTE       = 8'h00;

    // Highest PC whose full fetch window still lies inside memory.
    function automatic logic [PC_W-1:0] last_fetch_pc(input int unsigned mem_bytes);
        return PC_W'(mem_bytes - INSTR_MAX_BYTES);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader byte stream, load status and fetch read port of the instruction memory.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) ();

    logic                ld_start;
    logic [ADDR_W-1:0]   ld_base;
    logic                ld_valid;
    logic [7:0]          ld_data;
    logic                ld_last;
    logic                ld_ready;
    logic                ld_done;
    logic                ld_err;
    logic [ADDR_W:0]     ld_count;
    logic                fetch_en;
    logic [PC_W-1:0]     PC;
    logic [INSTR_W-1:0]  instr_bytes;
    logic                imem_er;

    modport master (
        output ld_start, ld_base, ld_valid, ld_data, ld_last, PC,
        input  ld_ready, ld_done, ld_err, ld_count, fetch_en, instr_bytes, imem_er
    );

    modport slave (
        input  ld_start, ld_base, ld_valid, ld_data, ld_last, PC,
        output ld_ready, ld_done, ld_err, ld_count, fetch_en, instr_bytes, imem_er
    );

endinterface

// File: rtl/imem_array.sv
// Byte-wide instruction memory: one synchronous write port and a combinational
// ten-byte fetch window; contents are deliberately not reset.
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_data,
    input  logic [PC_W-1:0]    rd_pc,
    output logic [INSTR_W-1:0] rd_bytes,
    output logic               rd_err
);

    logic [7:0]        mem [MEM_BYTES];
    logic [ADDR_W-1:0] rd_base_c;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Full-width compare so a huge PC can never alias onto a legal address.
    always_comb begin
        rd_err    = (rd_pc > last_fetch_pc(MEM_BYTES));
        rd_base_c = rd_pc[ADDR_W-1:0];
        rd_bytes  = {INSTR_MAX_BYTES{HALT_BYTE}};
        if (!rd_err) begin
            for (int k = 0; k < int'(INSTR_MAX_BYTES); k++) begin
                rd_bytes[8*k +: 8] = mem[rd_base_c + ADDR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program byte-by-byte into the instruction memory and gates the
// fetch stage until the load completes; the memory read port is always live.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(MEM_BYTES - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ld_ready_q, ld_ready_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_err_q, ld_err_d;
    logic              fetch_en_q, fetch_en_d;
    logic              accept_c;

    assign accept_c = bus.ld_valid && ld_ready_q;

    // Next-state, pointer and counter; the pointer saturates at the top byte.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    ptr_d   = bus.ld_base;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    count_d = count_q + CNT_W'(1);
                    if (bus.ld_last) begin
                        state_d = DONE;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d = ERR;
                    end
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ld_ready_d = (state_d == LOAD);
        ld_done_d  = (state_d == DONE);
        ld_err_d   = (state_d == ERR);
        fetch_en_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
            fetch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            ld_ready_q <= ld_ready_d;
            ld_done_q  <= ld_done_d;
            ld_err_q   <= ld_err_d;
            fetch_en_q <= fetch_en_d;
        end
    end

    imem_array #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk      (clk),
        .wr_en    (accept_c),
        .wr_addr  (ptr_q),
        .wr_data  (bus.ld_data),
        .rd_pc    (bus.PC),
        .rd_bytes (bus.instr_bytes),
        .rd_err   (bus.imem_er)
    );

    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_err   = ld_err_q;
    assign bus.ld_count = count_q;
    assign bus.fetch_en = fetch_en_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a transaction-level model of the
// memory image and load outcome.
module tb_imem_loader;

    localparam int MEM     = 1024;
    localparam int LAST_PC = MEM - 10;

    logic clk;
    logic rst_n;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(
        .MEM_BYTES (MEM),
        .ADDR_W    (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic [7:0] mm    [MEM];
    bit         known [MEM];
    logic [7:0] prog  [1100];
    bit         m_done;
    bit         m_err;
    int         m_cnt;
    bit         loading;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected fetch window from the memory image; unwritten bytes are masked.
    task automatic chk_fetch(input string tag);
        logic [63:0] pc;
        logic [79:0] exp;
        logic [79:0] mask;
        int idx;
        pc   = bus.PC;
        exp  = '0;
        mask = '1;
        if (pc <= 64'(LAST_PC)) begin
            for (int k = 0; k < 10; k++) begin
                idx = int'(pc[9:0]) + k;
                exp[8*k +: 8]  = mm[idx];
                mask[8*k +: 8] = known[idx] ? 8'hFF : 8'h00;
            end
        end
        chk({tag, "_instr"}, bus.instr_bytes & mask, exp & mask);
        chk({tag, "_er"}, 80'(bus.imem_er), 80'(pc > 64'(LAST_PC)));
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_ready"}, 80'(bus.ld_ready), 80'(loading));
        chk({tag, "_done"},  80'(bus.ld_done),  80'(m_done));
        chk({tag, "_err"},   80'(bus.ld_err),   80'(m_err));
        chk({tag, "_fetch"}, 80'(bus.fetch_en), 80'(m_done));
        chk({tag, "_count"}, 80'(bus.ld_count), 80'(m_cnt));
    endtask

    task automatic idle_inputs();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = 8'h00;
    endtask

    // Start a load of prog[0..n-1] at base; returns early after abort_after bytes.
    task automatic run_load(input int base, input int n, input int gap_pct,
                            input int abort_after, input logic [63:0] pc);
        int i;
        int cyc;
        bus.PC       = pc;
        bus.ld_start = 1'b1;
        bus.ld_base  = 10'(base);
        bus.ld_valid = 1'b0;
        #1 chk_fetch("rd_start");
        @(posedge clk);
        loading = 1'b1;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        #1;
        chk("start_ready", 80'(bus.ld_ready), 80'(1));
        chk("start_count", 80'(bus.ld_count), 80'(0));
        i   = 0;
        cyc = 0;
        while (loading && cyc < 6000) begin
            if (abort_after >= 0 && i == abort_after) return;
            bus.ld_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.ld_data  = bus.ld_valid ? prog[i] : 8'($urandom);
            bus.ld_last  = bus.ld_valid ? (i == n - 1) : 1'($urandom);
            bus.ld_start = ($urandom_range(0, 7) == 0);
            bus.ld_base  = 10'($urandom);
            #1 chk_fetch("rd_pre");
            @(posedge clk);
            if (bus.ld_valid) begin
                mm[base + i]    = prog[i];
                known[base + i] = 1'b1;
                i++;
                m_cnt = i;
                if (i == n) begin
                    loading = 1'b0;
                    m_done  = 1'b1;
                end else if (base + i == MEM) begin
                    loading = 1'b0;
                    m_err   = 1'b1;
                end
            end
            #1;
            chk("load_count", 80'(bus.ld_count), 80'(m_cnt));
            chk("load_ready", 80'(bus.ld_ready), 80'(loading));
            cyc++;
        end
        idle_inputs();
        if (loading) chk("load_timeout", 80'(0), 80'(1));
        chk_status("end");
        #1 chk_fetch("rd_post");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        loading = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        idle_inputs();
        #1 chk_status("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic scan_pc(input logic [63:0] pc, input string tag);
        bus.PC = pc;
        #1 chk_fetch(tag);
    endtask

    initial begin
        int base;
        int n;
        logic [63:0] pc;
        logic [79:0] ib;
        total = 0;
        bad   = 0;
        for (int a = 0; a < MEM; a++) known[a] = 1'b0;
        rst_n = 1'b0;
        bus.PC      = 64'd0;
        bus.ld_base = '0;
        idle_inputs();
        loading = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        #3 chk_status("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the whole memory; the last byte lands on the top address with ld_last.
        for (int a = 0; a < MEM; a++) prog[a] = 8'($urandom);
        run_load(0, MEM, 20, -1, 64'd0);
        chk("full_done", 80'(bus.ld_done), 80'(1));

        scan_pc(64'd0, "pc0");
        scan_pc(64'd1014, "pc1014");
        scan_pc(64'd1015, "pc1015");
        chk("pc1015_zero", bus.instr_bytes, 80'(0));
        scan_pc(64'hFFFF_FFFF_FFFF_FFFF, "pc_max");
        scan_pc(64'h0000_0001_0000_0000, "pc_alias");
        scan_pc(64'd1023, "pc1023");

        // Y86 irmovq prefix at address 0.
        prog[0] = 8'h30;
        prog[1] = 8'hF4;
        for (int a = 2; a < 10; a++) prog[a] = 8'h00;
        run_load(0, 10, 30, -1, 64'd0);
        ib = bus.instr_bytes;
        chk("y86_count", 80'(bus.ld_count), 80'(10));
        chk("y86_b0", 80'(ib[7:0]), 80'(8'h30));
        chk("y86_b1", 80'(ib[15:8]), 80'(8'hF4));

        for (int a = 0; a < 20; a++) prog[a] = 8'($urandom);
        run_load(100, 20, 60, -1, 64'd98);

        // Overflow: four bytes fit, the fifth must be refused.
        for (int a = 0; a < 5; a++) prog[a] = 8'($urandom);
        run_load(1020, 5, 0, -1, 64'd1014);
        chk("ovf_err", 80'(bus.ld_err), 80'(1));
        chk("ovf_count", 80'(bus.ld_count), 80'(4));
        for (int c = 0; c < 3; c++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[4];
            bus.ld_last  = 1'b0;
            @(posedge clk);
            #1 chk_status("ovf_hold");
        end
        idle_inputs();
        scan_pc(64'd1014, "ovf_rd");

        // Write to address 5 while fetching from 0.
        prog[0] = ~mm[5];
        run_load(5, 1, 0, -1, 64'd0);

        // Reset mid-load keeps bytes already written.
        for (int a = 0; a < 6; a++) prog[a] = 8'($urandom);
        run_load(200, 6, 0, 3, 64'd198);
        do_reset();
        scan_pc(64'd198, "abort_rd");
        for (int a = 0; a < 6; a++) prog[a] = 8'($urandom);
        run_load(200, 6, 25, -1, 64'd198);
        chk("reload_done", 80'(bus.ld_done), 80'(1));

        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                base = $urandom_range(980, 1023);
                n    = (MEM - base) + $urandom_range(0, 3);
            end else begin
                base = $urandom_range(0, 1023);
                n    = $urandom_range(1, 40);
            end
            for (int a = 0; a < n; a++) prog[a] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       pc = {32'($urandom), 32'($urandom)};
                1:       pc = 64'($urandom_range(0, 1023));
                default: pc = 64'((base > 9) ? base - $urandom_range(0, 9) : 0);
            endcase
            run_load(base, n, $urandom_range(0, 50), -1, pc);
            for (int s = 0; s < 4; s++) scan_pc(64'($urandom_range(0, LAST_PC)), "rand_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
